sme_preamble_stitcher: RTL and testbench
========================================

Name: sme_preamble_stitcher

Overview:
- Parametrised successor to the fixed 16-byte/7-byte preamble front end of the Pigasus SME path.
- Prepends a per-flow preamble (tail of the previous packet of the flow) to each packet, realigns the stream, and inserts the extra tail beat when needed.
- Accepts per-packet state via a valid/ready handshake and returns the updated flow state via a held valid/ready output.
- Sits between the RISC-V/DMA packet stream and string_matcher; each packet is framed by one state-in and one state-out transaction.

Parameters:
- BYTE_COUNT, 16, bytes per beat (B); power of two, 4..64.
- PRE_BYTES, 7, preamble length P; 1 <= P <= B-1.
- EMPTY_W, $clog2(BYTE_COUNT), width of tempty fields.
- STATE_W, 8*PRE_BYTES+8, state word width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- s_axis_tdata  in  8B  input data; byte 0 = first on wire, at [7:0]
- s_axis_tempty  in  EMPTY_W  count of invalid top bytes; valid only with tlast
- s_axis_tvalid / s_axis_tlast  in  1  stream valid / last beat
- s_axis_tready  out  1  stream ready
- s_state_data  in  STATE_W  [8P-1:0] preamble (byte 0 oldest), [8P] is_tcp, [8P+4] has_pre, other bits passthrough
- s_state_valid  in  1 / s_state_ready  out  1  state-in handshake
- m_axis_tdata  out  8B; m_axis_tempty  out  EMPTY_W
- m_axis_tvalid / m_axis_tlast / m_axis_tfirst  out  1
- m_axis_tready  in  1
- m_state_data  out  STATE_W; m_state_valid  out  1; m_state_ready  in  1

Behaviour:
- Reset state: IDLE.
  - Outputs at reset: s_axis_tready=0, s_state_ready=1, m_axis_tvalid=0, m_state_valid=0, carry=all 0xFF.
- FSM:
  - IDLE: s_state_ready=1. On s_state_valid, latch state into the carry register and the pre/tcp flags, then go to STREAM.
  - STREAM: passthrough combinational, zero latency. s_axis_tready=m_axis_tready, m_axis_tvalid=s_axis_tvalid. m_axis_tfirst=1 on the first beat of the packet.
  - On the accepted last beat: go to EXTRA if has_pre and tempty<P, else go to DONE.
  - EXTRA: one registered beat. s_axis_tready=0, m_axis_tvalid=1, tlast=1. Hold until m_axis_tready, then go to DONE.
  - DONE: m_state_valid=1, data held stable until m_state_ready, then go to IDLE.
  - s_state_ready=0 in every state except IDLE.
- Data mapping when has_pre=0: m_axis = s_axis unchanged, including tempty and tlast.
- Data mapping when has_pre=1:
  - Output bytes 0..P-1 = carry. Output bytes P..B-1 = input bytes 0..B-P-1.
  - After each accepted beat, carry <= input bytes B-P..B-1.
  - Last input beat with tempty>=P: tlast=1, out tempty = tempty-P.
  - Last input beat with tempty<P: that beat has tlast=0 and tempty=0. The EXTRA beat follows with bytes 0..P-1 = carry, upper bytes 0xFF, tempty = B-P+tempty_in.
- m_state_data[8P-1:0] = last P valid bytes of the concatenation {carry-at-start-of-beat, last beat}.
  - The concatenation is P+B bytes, carry at the low end; the result is a right shift by 8*(B-tempty).
  - If has_pre=0 on a single-beat packet, the carry is 0xFF fill, so short packets pad with 0xFF.
- Upper state bits: m_state_data[8P+4] = is_tcp, [8P] = is_tcp, other upper bits = passthrough of latched s_state_data.
- Single-beat packet: tfirst and tlast both 1 on the same beat. The same-cycle combinational path is legal.
- Backpressure: no bytes are lost or duplicated when m_axis_tready toggles in any state.
- s_axis_tvalid while not in STREAM: ignored (tready=0).
- Reset mid-packet: FSM returns to IDLE immediately; the in-flight packet and its state are discarded.

Optional Feature:
- Macro SME_STITCH_STATS_EN.
- Defined:
  - Adds outputs stat_pkt_cnt[31:0] (increments on each m_state handshake) and stat_extra_cnt[31:0] (increments on each EXTRA beat handshake).
  - Both wrap modulo 2^32 and reset to 0.
- Undefined: the ports and counters are absent; the rest of the behaviour is identical.

Test Plan:
- Setup for all cases: B=16, P=7.
- has_pre=0, 1-beat packet 0x00..0x0B with tempty=4 -> one out beat identical to input, tempty=4, tlast=1. m_state preamble = bytes 0x05..0x0B, [60]=is_tcp.
- has_pre=1, preamble 0xA0..0xA6, 2 beats 0x00..0x1F with tempty=0 on last:
  - 3 out beats: {A0..A6,00..08}, {09..0F,10..18}, extra {19..1F, FF*9} with tempty=9.
  - m_state preamble = 0x19..0x1F; stat_extra_cnt +1.
- has_pre=1, 1 beat of 3 bytes 0x00..0x02 (tempty=13) -> one beat {A0..A6,00..02}, tempty=6, tlast=1. m_state preamble = {A3,A4,A5,A6,00,01,02}.
- Random m_axis_tready (50%) and random m_state_ready over 200 packets with random lengths -> scoreboard shows byte-exact output and state chaining matches the reference model.
- Assert rst during the middle beat of a 3-beat packet -> next cycle m_axis_tvalid=0, s_state_ready=1. The next packet is processed correctly from its own fresh state.
- s_state_valid held high during DONE -> s_state_ready stays 0 until m_state handshake, then the state is accepted exactly once.

Source files
------------

// File: rtl/sme_preamble_stitcher.sv
// Prepends the per-flow preamble to each packet, realigns the stream and emits the trailing beat.
// Optional statistics counters are enabled by defining SME_STITCH_STATS_EN.
module sme_preamble_stitcher #(
  parameter int BYTE_COUNT = 16,
  parameter int PRE_BYTES  = 7,
  parameter int EMPTY_W    = $clog2(BYTE_COUNT),
  parameter int STATE_W    = 8*PRE_BYTES+8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [8*BYTE_COUNT-1:0] s_axis_tdata,
  input  logic [EMPTY_W-1:0]      s_axis_tempty,
  input  logic                    s_axis_tvalid,
  input  logic                    s_axis_tlast,
  output logic                    s_axis_tready,
  input  logic [STATE_W-1:0]      s_state_data,
  input  logic                    s_state_valid,
  output logic                    s_state_ready,
  output logic [8*BYTE_COUNT-1:0] m_axis_tdata,
  output logic [EMPTY_W-1:0]      m_axis_tempty,
  output logic                    m_axis_tvalid,
  output logic                    m_axis_tlast,
  output logic                    m_axis_tfirst,
  input  logic                    m_axis_tready,
  output logic [STATE_W-1:0]      m_state_data,
  output logic                    m_state_valid,
  input  logic                    m_state_ready
`ifdef SME_STITCH_STATS_EN
  ,
  output logic [31:0]             stat_pkt_cnt,
  output logic [31:0]             stat_extra_cnt
`endif
);

  localparam int B   = BYTE_COUNT;
  localparam int P   = PRE_BYTES;
  localparam int DW  = 8*B;
  localparam int PW  = 8*P;
  localparam int UW  = STATE_W-PW;
  localparam int SHW = $clog2(B)+1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] STREAM = 2'd1;
  localparam logic [1:0] EXTRA  = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [PW-1:0]      carry_q, carry_d;
  logic               has_pre_q, has_pre_d;
  logic               is_tcp_q, is_tcp_d;
  logic [UW-1:0]      upper_q, upper_d;
  logic               first_q, first_d;
  logic [EMPTY_W-1:0] xempty_q, xempty_d;
  logic [STATE_W-1:0] st_out_q, st_out_d;

  logic               short_last;
  logic [SHW+2:0]     shamt;
  logic [PW-1:0]      pre_next;
  logic [UW-1:0]      upper_out;

  // A last beat with fewer than P spare bytes cannot absorb the preamble shift.
  assign short_last = has_pre_q && (s_axis_tempty < EMPTY_W'(P));
  assign shamt      = {SHW'(B) - SHW'(s_axis_tempty), 3'b000};
  assign pre_next   = PW'({s_axis_tdata, carry_q} >> shamt);

  always_comb begin
    upper_out    = upper_q;
    upper_out[0] = is_tcp_q;
    upper_out[4] = is_tcp_q;
  end

  always_comb begin
    s_axis_tready = 1'b0;
    s_state_ready = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = s_axis_tdata;
    m_axis_tempty = s_axis_tempty;
    m_axis_tlast  = 1'b0;
    m_axis_tfirst = 1'b0;
    m_state_valid = 1'b0;
    m_state_data  = st_out_q;
    case (state_q)
      IDLE: s_state_ready = 1'b1;
      STREAM: begin
        s_axis_tready = m_axis_tready;
        m_axis_tvalid = s_axis_tvalid;
        m_axis_tfirst = first_q;
        if (has_pre_q) begin
          m_axis_tdata  = {s_axis_tdata[DW-PW-1:0], carry_q};
          m_axis_tlast  = s_axis_tlast && !short_last;
          m_axis_tempty = (s_axis_tlast && !short_last) ?
                          (s_axis_tempty - EMPTY_W'(P)) : '0;
        end else begin
          m_axis_tlast  = s_axis_tlast;
        end
      end
      EXTRA: begin
        m_axis_tvalid = 1'b1;
        m_axis_tlast  = 1'b1;
        m_axis_tdata  = {{(DW-PW){1'b1}}, carry_q};
        m_axis_tempty = xempty_q;
      end
      default: m_state_valid = 1'b1;
    endcase
  end

  // Without a preamble the carry starts as 0xFF fill so short packets pad the outgoing state.
  always_comb begin
    state_d   = state_q;
    carry_d   = carry_q;
    has_pre_d = has_pre_q;
    is_tcp_d  = is_tcp_q;
    upper_d   = upper_q;
    first_d   = first_q;
    xempty_d  = xempty_q;
    st_out_d  = st_out_q;
    case (state_q)
      IDLE: begin
        if (s_state_valid) begin
          carry_d   = s_state_data[PW+4] ? s_state_data[PW-1:0] : '1;
          has_pre_d = s_state_data[PW+4];
          is_tcp_d  = s_state_data[PW];
          upper_d   = s_state_data[STATE_W-1:PW];
          first_d   = 1'b1;
          state_d   = STREAM;
        end
      end
      STREAM: begin
        if (s_axis_tvalid && m_axis_tready) begin
          carry_d = s_axis_tdata[DW-1:DW-PW];
          first_d = 1'b0;
          if (s_axis_tlast) begin
            st_out_d = {upper_out, pre_next};
            xempty_d = EMPTY_W'(B-P) + s_axis_tempty;
            state_d  = short_last ? EXTRA : DONE;
          end
        end
      end
      EXTRA: begin
        if (m_axis_tready) state_d = DONE;
      end
      default: begin
        if (m_state_ready) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      carry_q   <= '1;
      has_pre_q <= 1'b0;
      is_tcp_q  <= 1'b0;
      upper_q   <= '0;
      first_q   <= 1'b0;
      xempty_q  <= '0;
      st_out_q  <= '0;
    end else begin
      state_q   <= state_d;
      carry_q   <= carry_d;
      has_pre_q <= has_pre_d;
      is_tcp_q  <= is_tcp_d;
      upper_q   <= upper_d;
      first_q   <= first_d;
      xempty_q  <= xempty_d;
      st_out_q  <= st_out_d;
    end
  end

`ifdef SME_STITCH_STATS_EN
  logic [31:0] pkt_cnt_q, extra_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_cnt_q   <= '0;
      extra_cnt_q <= '0;
    end else begin
      if (state_q == DONE && m_state_ready) pkt_cnt_q <= pkt_cnt_q + 32'd1;
      if (state_q == EXTRA && m_axis_tready) extra_cnt_q <= extra_cnt_q + 32'd1;
    end
  end

  assign stat_pkt_cnt   = pkt_cnt_q;
  assign stat_extra_cnt = extra_cnt_q;
`endif

endmodule

// File: tb/tb_sme_preamble_stitcher.sv
// Scoreboard bench for sme_preamble_stitcher (B=16, P=7): byte-level reference model
// predicts output beats and the chained flow state; a negedge monitor compares them.
module tb_sme_preamble_stitcher;

  localparam int B  = 16;
  localparam int P  = 7;
  localparam int SW = 8*P+8;

  typedef struct packed {
    logic [127:0] data;
    logic [3:0]   tempty;
    logic         tlast;
    logic         tfirst;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [127:0]  s_axis_tdata = '0;
  logic [3:0]    s_axis_tempty = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tlast = 1'b0;
  logic          s_axis_tready;
  logic [SW-1:0] s_state_data = '0;
  logic          s_state_valid = 1'b0;
  logic          s_state_ready;
  logic [127:0]  m_axis_tdata;
  logic [3:0]    m_axis_tempty;
  logic          m_axis_tvalid;
  logic          m_axis_tlast;
  logic          m_axis_tfirst;
  logic          m_axis_tready = 1'b0;
  logic [SW-1:0] m_state_data;
  logic          m_state_valid;
  logic          m_state_ready = 1'b0;
`ifdef SME_STITCH_STATS_EN
  logic [31:0]   stat_pkt_cnt;
  logic [31:0]   stat_extra_cnt;
`endif

  sme_preamble_stitcher #(.BYTE_COUNT(B), .PRE_BYTES(P)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tempty(s_axis_tempty),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
    .s_axis_tready(s_axis_tready),
    .s_state_data(s_state_data), .s_state_valid(s_state_valid),
    .s_state_ready(s_state_ready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tempty(m_axis_tempty),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
    .m_axis_tfirst(m_axis_tfirst), .m_axis_tready(m_axis_tready),
    .m_state_data(m_state_data), .m_state_valid(m_state_valid),
    .m_state_ready(m_state_ready)
`ifdef SME_STITCH_STATS_EN
    ,
    .stat_pkt_cnt(stat_pkt_cnt), .stat_extra_cnt(stat_extra_cnt)
`endif
  );

  always #5 clk = ~clk;

  int            errCnt = 0;
  int            checkCnt = 0;
  int            stateAcceptCnt = 0;
  bit            ignoreOut = 1'b0;
  bit            forceReady = 1'b0;
  bit            holdState = 1'b0;
  beat_t         expBeats[$];
  logic [SW-1:0] expStates[$];
  logic [7:0]    pktBytes[0:127];
  logic [3:0]    midTempty[0:7];
  int            pktLen;

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checkCnt++;
    if (obs !== exp) begin
      errCnt++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Sink-side readiness: random unless a test pins it.
  initial forever begin
    @(posedge clk);
    #1;
    m_axis_tready = forceReady ? 1'b1 : 1'($urandom_range(0, 1));
    m_state_ready = holdState ? 1'b0 : 1'($urandom_range(0, 1));
  end

  // Monitor: sampled on the falling edge, where the coming handshake is already settled.
  always @(negedge clk) begin
    if (!rst) begin
      if (s_state_valid && s_state_ready) stateAcceptCnt++;
      if (!ignoreOut && m_axis_tvalid && m_axis_tready) begin
        if (expBeats.size() == 0) checkOutput("unexpected_beat", 1, 0);
        else begin
          beat_t e;
          e = expBeats.pop_front();
          checkOutput("beat_data", m_axis_tdata, e.data);
          checkOutput("beat_tempty", 128'(m_axis_tempty), 128'(e.tempty));
          checkOutput("beat_tlast", 128'(m_axis_tlast), 128'(e.tlast));
          checkOutput("beat_tfirst", 128'(m_axis_tfirst), 128'(e.tfirst));
        end
      end
      if (!ignoreOut && m_state_valid && m_state_ready) begin
        if (expStates.size() == 0) checkOutput("unexpected_state", 1, 0);
        else checkOutput("state_out", 128'(m_state_data), 128'(expStates.pop_front()));
      end
    end
  end

  // Reference model: preamble bytes followed by the raw input bytes, re-cut into beats.
  task automatic predictPacket(input logic [SW-1:0] st, output logic [SW-1:0] stOut);
    logic [7:0] strm[0:143];
    logic       hasPre, isTcp, extra;
    int         n, nIn, tIn, nOut, valid;
    beat_t      e;
    hasPre = st[8*P+4];
    isTcp  = st[8*P];
    nIn    = (pktLen + B - 1) / B;
    tIn    = nIn*B - pktLen;
    n      = 0;
    if (hasPre) for (int i = 0; i < P; i++) begin strm[n] = st[8*i +: 8]; n++; end
    for (int i = 0; i < nIn*B; i++) begin strm[n] = pktBytes[i]; n++; end
    valid = pktLen + (hasPre ? P : 0);
    extra = hasPre && (tIn < P);
    nOut  = nIn + (extra ? 1 : 0);
    for (int k = 0; k < nOut; k++) begin
      for (int j = 0; j < B; j++) e.data[8*j +: 8] = (k*B+j < n) ? strm[k*B+j] : 8'hFF;
      e.tlast  = (k == nOut-1);
      e.tfirst = (k == 0);
      if (k == nOut-1) e.tempty = 4'(nOut*B - valid);
      else             e.tempty = hasPre ? 4'd0 : midTempty[k];
      expBeats.push_back(e);
    end
    for (int i = 0; i < P; i++) begin
      int x;
      x = pktLen + i;
      if (x < P) stOut[8*i +: 8] = hasPre ? st[8*x +: 8] : 8'hFF;
      else       stOut[8*i +: 8] = pktBytes[x-P];
    end
    stOut[SW-1:8*P] = st[SW-1:8*P];
    stOut[8*P]      = isTcp;
    stOut[8*P+4]    = isTcp;
    expStates.push_back(stOut);
  endtask

  task automatic sendState(input logic [SW-1:0] st);
    logic got;
    got = 1'b0;
    s_state_valid = 1'b1;
    s_state_data  = st;
    for (int n = 0; n < 1000 && !got; n++) begin
      @(negedge clk);
      got = s_state_ready;
      @(posedge clk);
      #1;
    end
    s_state_valid = 1'b0;
    if (!got) checkOutput("state_in_timeout", 128'(got), 1);
  endtask

  task automatic sendBeat(input logic [127:0] d, input logic [3:0] te, input logic last);
    logic got;
    got = 1'b0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tempty = te;
    s_axis_tlast  = last;
    for (int n = 0; n < 1000 && !got; n++) begin
      @(negedge clk);
      got = s_axis_tready;
      @(posedge clk);
      #1;
    end
    s_axis_tvalid = 1'b0;
    if (!got) checkOutput("beat_in_timeout", 128'(got), 1);
  endtask

  task automatic sendBeats();
    int nIn;
    logic [127:0] d;
    nIn = (pktLen + B - 1) / B;
    for (int k = 0; k < nIn; k++) begin
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
      for (int j = 0; j < B; j++) d[8*j +: 8] = pktBytes[k*B+j];
      sendBeat(d, (k == nIn-1) ? 4'(nIn*B - pktLen) : midTempty[k], k == nIn-1);
    end
  endtask

  task automatic applyStimulus(input logic [SW-1:0] st, output logic [SW-1:0] stOut);
    predictPacket(st, stOut);
    sendState(st);
    sendBeats();
  endtask

  task automatic fillPacket(input int len, input bit ramp, input logic [7:0] base);
    pktLen = len;
    for (int i = 0; i < 128; i++) pktBytes[i] = (ramp && i < len) ? 8'(base + i) : 8'($urandom);
    for (int i = 0; i < 8; i++) midTempty[i] = 4'($urandom);
  endtask

  task automatic drain();
    for (int n = 0; n < 2000 && (expBeats.size() != 0 || expStates.size() != 0); n++) @(negedge clk);
    checkOutput("beats_pending", 128'(expBeats.size()), 0);
    checkOutput("states_pending", 128'(expStates.size()), 0);
    @(posedge clk);
    #1;
  endtask

  logic [SW-1:0] st, stOut, stNext;
  int            cntBefore;
`ifdef SME_STITCH_STATS_EN
  logic [31:0]   extraBefore;
`endif

  initial begin
    repeat (3) @(negedge clk);
    checkOutput("rst_s_axis_tready", 128'(s_axis_tready), 0);
    checkOutput("rst_s_state_ready", 128'(s_state_ready), 1);
    checkOutput("rst_m_axis_tvalid", 128'(m_axis_tvalid), 0);
    checkOutput("rst_m_state_valid", 128'(m_state_valid), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // No preamble, 12-byte single beat.
    fillPacket(12, 1'b1, 8'h00);
    st = {8'h01, 56'h0};
    applyStimulus(st, stOut);
    drain();

    // Preamble A0..A6, two full beats: the extra beat is required.
`ifdef SME_STITCH_STATS_EN
    extraBefore = stat_extra_cnt;
`endif
    fillPacket(32, 1'b1, 8'h00);
    for (int i = 0; i < P; i++) st[8*i +: 8] = 8'(8'hA0 + i);
    st[SW-1:8*P] = 8'h11;
    applyStimulus(st, stOut);
    drain();
`ifdef SME_STITCH_STATS_EN
    checkOutput("stat_extra_cnt", 128'(stat_extra_cnt), 128'(extraBefore + 32'd1));
`endif

    // Preamble with a 3-byte packet.
    fillPacket(3, 1'b1, 8'h00);
    applyStimulus(st, stOut);
    drain();

    // Incoming state held valid across DONE must be taken exactly once.
    holdState = 1'b1;
    fillPacket(20, 1'b1, 8'h40);
    applyStimulus(st, stOut);
    stNext = stOut;
    stNext[8*P] = 1'b0;
    s_state_valid = 1'b1;
    s_state_data  = stNext;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput("done_hold_ready", 128'(s_state_ready), 0);
    end
    cntBefore = stateAcceptCnt;
    holdState = 1'b0;
    @(posedge clk);
    #1;
    fillPacket(9, 1'b1, 8'h60);
    predictPacket(stNext, stOut);
    sendState(stNext);
    repeat (3) @(negedge clk);
    checkOutput("state_accept_once", 128'(stateAcceptCnt), 128'(cntBefore + 1));
    @(posedge clk);
    #1;
    sendBeats();
    drain();

    // Reset in the middle beat of a 3-beat packet.
    ignoreOut  = 1'b1;
    forceReady = 1'b1;
    @(posedge clk);
    #1;
    fillPacket(40, 1'b1, 8'h80);
    sendState(st);
    sendBeat({pktBytes[15], pktBytes[14], pktBytes[13], pktBytes[12], pktBytes[11], pktBytes[10],
              pktBytes[9], pktBytes[8], pktBytes[7], pktBytes[6], pktBytes[5], pktBytes[4],
              pktBytes[3], pktBytes[2], pktBytes[1], pktBytes[0]}, 4'd0, 1'b0);
    s_axis_tvalid = 1'b1;
    s_axis_tlast  = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    s_axis_tvalid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("midrst_m_axis_tvalid", 128'(m_axis_tvalid), 0);
    checkOutput("midrst_s_state_ready", 128'(s_state_ready), 1);
    checkOutput("midrst_s_axis_tready", 128'(s_axis_tready), 0);
    @(negedge clk);
    rst = 1'b0;
    ignoreOut  = 1'b0;
    forceReady = 1'b0;
    @(posedge clk);
    #1;
    fillPacket(21, 1'b1, 8'hC0);
    for (int i = 0; i < P; i++) st[8*i +: 8] = 8'(8'h30 + i);
    st[SW-1:8*P] = 8'h11;
    applyStimulus(st, stOut);
    drain();

    // Random lengths with state chained from one packet to the next.
    for (int p = 0; p < 200; p++) begin
      fillPacket($urandom_range(1, 64), 1'b0, 8'h00);
      st = stOut;
      st[8*P] = 1'($urandom);
      {st[8*P+7:8*P+5], st[8*P+3:8*P+1]} = 6'($urandom);
      applyStimulus(st, stOut);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errCnt, checkCnt);
    $finish;
  end

endmodule
